// File: rtl/door_lock_pkg.sv
// Shared definitions for the keypad door lock (code writer and lock checker):
// FSM state encoding, result LED patterns, digit width and keypad helpers.
package door_lock_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        CONFIRM = 3'd2,
        CHECK   = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_PASS = 2'b10;
    localparam logic [1:0] LED_FAIL = 2'b01;

    // Number of keys asserted in a 10-bit keypad vector.
    function automatic logic [3:0] count_keys(input logic [9:0] keys);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, keys[i]};
        end
        return n;
    endfunction

    // Digit of the highest set key; only meaningful for a one-hot vector.
    function automatic logic [DIGIT_W-1:0] onehot_to_digit(input logic [9:0] keys);
        logic [DIGIT_W-1:0] digit;
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) begin
                digit = DIGIT_W'(i);
            end else begin
                digit = digit;
            end
        end
        return digit;
    endfunction

endpackage

// File: rtl/door_lock_code_writer_key_edge_decode.sv
// Keypad input conditioning: rising-edge detection on prog and on every
// button bit, followed by one-hot to digit decode. All outputs are registered
// pulses, so a held button produces exactly one pulse.
module key_edge_decode
    import door_lock_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               prog,
    input  logic [9:0]         button,
    output logic               prog_pulse,
    output logic               key_valid,
    output logic               key_invalid,
    output logic [DIGIT_W-1:0] key_digit
);

    logic               prog_hist_q;
    logic [9:0]         btn_hist_q;
    logic [9:0]         key_edge_s;
    logic [3:0]         key_count_s;
    logic               prog_pulse_q;
    logic               key_valid_q;
    logic               key_invalid_q;
    logic [DIGIT_W-1:0] key_digit_q;

    // Rising edges of the raw buttons against last cycle's levels.
    always_comb begin
        key_edge_s  = button & ~btn_hist_q;
        key_count_s = count_keys(key_edge_s);
    end

    // Input history and registered edge/decode results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_hist_q   <= 1'b0;
            btn_hist_q    <= 10'd0;
            prog_pulse_q  <= 1'b0;
            key_valid_q   <= 1'b0;
            key_invalid_q <= 1'b0;
            key_digit_q   <= 4'd0;
        end else begin
            prog_hist_q   <= prog;
            btn_hist_q    <= button;
            prog_pulse_q  <= prog & ~prog_hist_q;
            key_valid_q   <= (key_count_s == 4'd1);
            key_invalid_q <= (key_count_s > 4'd1);
            key_digit_q   <= onehot_to_digit(key_edge_s);
        end
    end

    assign prog_pulse  = prog_pulse_q;
    assign key_valid   = key_valid_q;
    assign key_invalid = key_invalid_q;
    assign key_digit   = key_digit_q;

endmodule

// File: rtl/door_lock_code_writer.sv
// Enrollment side of the keypad door lock: captures a new code, asks for it
// again, and commits it only when both entries match.
// Optional build macro CODE_WRITER_TIMEOUT_EN aborts an entry that sits idle
// for TIMEOUT cycles; without it ENTER/CONFIRM wait indefinitely.
module door_lock_code_writer
    import door_lock_pkg::*;
#(
    parameter int                          DIGITS        = 2,
    parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE  = 8'h80,
    parameter int                          LED_ON_PERIOD = 300,
    parameter int                          TIMEOUT       = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        prog,
    input  logic [9:0]                  button,
    output logic [DIGITS*DIGIT_W-1:0]   code,
    output logic                        code_update,
    output logic                        busy,
    output logic [1:0]                  led
);

    localparam int CODE_W    = DIGITS * DIGIT_W;
    localparam int IDX_W     = $clog2(DIGITS + 1);
    localparam int LED_CNT_W = $clog2(LED_ON_PERIOD + 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CODE_W-1:0]    entry_q, entry_d;
    logic [CODE_W-1:0]    confirm_q, confirm_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic                 code_update_q, code_update_d;
    logic [1:0]           led_q, led_d;
    logic [LED_CNT_W-1:0] led_cnt_q, led_cnt_d;
    logic                 busy_q;

    logic                 prog_pulse_s;
    logic                 key_valid_s;
    logic                 key_invalid_s;
    logic [DIGIT_W-1:0]   key_digit_s;
    logic                 last_digit_s;
    logic                 led_done_s;
    logic                 timeout_hit_s;

    // Writes a digit at entry position pos; position 0 is the top nibble.
    function automatic logic [CODE_W-1:0] put_nibble(input logic [CODE_W-1:0]  vec_in,
                                                     input logic [IDX_W-1:0]   pos,
                                                     input logic [DIGIT_W-1:0] digit);
        logic [CODE_W-1:0] vec_out;
        vec_out = vec_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (pos == IDX_W'(i)) begin
                vec_out[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit;
            end else begin
                vec_out = vec_out;
            end
        end
        return vec_out;
    endfunction

    key_edge_decode u_key_edge_decode (
        .clk         (clk),
        .rst         (rst),
        .prog        (prog),
        .button      (button),
        .prog_pulse  (prog_pulse_s),
        .key_valid   (key_valid_s),
        .key_invalid (key_invalid_s),
        .key_digit   (key_digit_s)
    );

    assign last_digit_s = (idx_q == IDX_W'(DIGITS - 1));
    assign led_done_s   = (led_cnt_q == LED_CNT_W'(LED_ON_PERIOD - 1));

`ifdef CODE_WRITER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Idle-time counter: runs while waiting for a key, saturates at TIMEOUT.
    always_comb begin
        tmo_d = tmo_q;
        if (((state_q == ENTER) || (state_q == CONFIRM)) && !prog_pulse_s && !key_valid_s) begin
            if (tmo_q != TMO_W'(TIMEOUT)) begin
                tmo_d = tmo_q + TMO_W'(1);
            end else begin
                tmo_d = tmo_q;
            end
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end
    end

    // Idle-time counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= {TMO_W{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_hit_s = (tmo_q == TMO_W'(TIMEOUT));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a prog edge always wins over a coincident key.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (prog_pulse_s) state_d = ENTER;
                else              state_d = IDLE;
            end
            ENTER, CONFIRM: begin
                if (prog_pulse_s)                     state_d = ENTER;
                else if (key_invalid_s)               state_d = SHOW;
                else if (key_valid_s && last_digit_s) state_d = (state_q == ENTER) ? CONFIRM : CHECK;
                else if (timeout_hit_s)               state_d = SHOW;
                else                                  state_d = state_q;
            end
            CHECK: begin
                state_d = SHOW;
            end
            SHOW: begin
                if (prog_pulse_s)    state_d = ENTER;
                else if (led_done_s) state_d = IDLE;
                else                 state_d = SHOW;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: digit buffers, code register and result LED.
    always_comb begin
        idx_d         = idx_q;
        entry_d       = entry_q;
        confirm_d     = confirm_q;
        code_d        = code_q;
        code_update_d = 1'b0;
        led_d         = led_q;
        led_cnt_d     = led_cnt_q;
        case (state_q)
            IDLE, SHOW: begin
                if (prog_pulse_s) begin
                    idx_d     = {IDX_W{1'b0}};
                    entry_d   = {CODE_W{1'b0}};
                    confirm_d = {CODE_W{1'b0}};
                    led_d     = LED_OFF;
                    led_cnt_d = {LED_CNT_W{1'b0}};
                end else if ((state_q == SHOW) && led_done_s) begin
                    led_d     = LED_OFF;
                    led_cnt_d = {LED_CNT_W{1'b0}};
                end else if (state_q == SHOW) begin
                    led_cnt_d = led_cnt_q + LED_CNT_W'(1);
                end else begin
                    led_cnt_d = led_cnt_q;
                end
            end
            ENTER, CONFIRM: begin
                if (prog_pulse_s) begin
                    idx_d     = {IDX_W{1'b0}};
                    entry_d   = {CODE_W{1'b0}};
                    confirm_d = {CODE_W{1'b0}};
                end else if (key_invalid_s) begin
                    led_d     = LED_FAIL;
                    led_cnt_d = {LED_CNT_W{1'b0}};
                end else if (key_valid_s) begin
                    if (state_q == ENTER) begin
                        entry_d = put_nibble(entry_q, idx_q, key_digit_s);
                    end else begin
                        confirm_d = put_nibble(confirm_q, idx_q, key_digit_s);
                    end
                    if (last_digit_s) idx_d = {IDX_W{1'b0}};
                    else              idx_d = idx_q + IDX_W'(1);
                end else if (timeout_hit_s) begin
                    led_d     = LED_FAIL;
                    led_cnt_d = {LED_CNT_W{1'b0}};
                end else begin
                    idx_d = idx_q;
                end
            end
            CHECK: begin
                led_cnt_d = {LED_CNT_W{1'b0}};
                if (entry_q == confirm_q) begin
                    code_d        = entry_q;
                    code_update_d = 1'b1;
                    led_d         = LED_PASS;
                end else begin
                    led_d         = LED_FAIL;
                end
            end
            default: begin
                idx_d = {IDX_W{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= {IDX_W{1'b0}};
            entry_q       <= {CODE_W{1'b0}};
            confirm_q     <= {CODE_W{1'b0}};
            code_q        <= DEFAULT_CODE;
            code_update_q <= 1'b0;
            led_q         <= LED_OFF;
            led_cnt_q     <= {LED_CNT_W{1'b0}};
            busy_q        <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            entry_q       <= entry_d;
            confirm_q     <= confirm_d;
            code_q        <= code_d;
            code_update_q <= code_update_d;
            led_q         <= led_d;
            led_cnt_q     <= led_cnt_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    assign code        = code_q;
    assign code_update = code_update_q;
    assign busy        = busy_q;
    assign led         = led_q;

endmodule

// File: tb/tb_door_lock_code_writer.sv
// Self-checking bench for door_lock_code_writer: directed cases plus random
// attempts, each predicted by a transaction-level model of enrollment.
module tb_door_lock_code_writer;

    localparam int DIGITS        = 2;
    localparam int LED_ON_PERIOD = 300;
    localparam int TIMEOUT       = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog;
    logic [9:0] button;
    logic [7:0] code;
    logic       code_update;
    logic       busy;
    logic [1:0] led;

    int checks   = 0;
    int failures = 0;

    typedef struct { bit p; logic [9:0] b; } ev_t;
    ev_t        evq[$];
    logic [7:0] model_code;

    int         upd_cnt  = 0;
    int         run_len  = 0;
    int         last_run = 0;
    int         episodes = 0;
    logic [1:0] run_led  = 2'b00;
    logic [1:0] last_led = 2'b00;

    always #5 clk = ~clk;

    door_lock_code_writer #(
        .DIGITS        (DIGITS),
        .DEFAULT_CODE  (8'h80),
        .LED_ON_PERIOD (LED_ON_PERIOD),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog        (prog),
        .button      (button),
        .code        (code),
        .code_update (code_update),
        .busy        (busy),
        .led         (led)
    );

    // Observe code_update pulses and lengths of lit-LED episodes.
    always @(negedge clk) begin
        if (code_update) upd_cnt++;
        if (led != 2'b00) begin
            run_len++;
            run_led = led;
        end else if (run_len > 0) begin
            last_run = run_len;
            last_led = run_led;
            episodes++;
            run_len  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(input bit p, input logic [9:0] b);
        ev_t e;
        e.p = p;
        e.b = b;
        return e;
    endfunction

    function automatic logic [9:0] digit_key(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    function automatic logic [9:0] bad_key();
        logic [9:0] b;
        int i, j;
        b = 10'($urandom);
        i = $urandom_range(0, 9);
        j = (i + 1 + $urandom_range(0, 8)) % 10;
        b[i] = 1'b1;
        b[j] = 1'b1;
        return b;
    endfunction

    // Enrollment as a user sees it: res 0 = still pending, 1 = pass, 2 = fail.
    function automatic void model_run(input ev_t q[$], inout logic [7:0] c, output int res);
        int phase;
        int first[$];
        int second[$];
        int d;
        bit same;
        int v;
        phase = 0;
        res   = 0;
        foreach (q[k]) begin
            if (q[k].p) begin
                phase = 1;
                res   = 0;
                first.delete();
                second.delete();
            end else if (phase == 0 || q[k].b == 10'd0) begin
                phase = phase;
            end else if ($countones(q[k].b) > 1) begin
                res   = 2;
                phase = 0;
            end else begin
                d = $clog2(q[k].b);
                if (phase == 1) begin
                    first.push_back(d);
                    if (first.size() == DIGITS) phase = 2;
                end else begin
                    second.push_back(d);
                    if (second.size() == DIGITS) begin
                        same = 1'b1;
                        v    = 0;
                        for (int i = 0; i < DIGITS; i++) begin
                            if (first[i] != second[i]) same = 1'b0;
                            v = v * 16 + first[i];
                        end
                        if (same) begin
                            c   = 8'(v);
                            res = 1;
                        end else begin
                            res = 2;
                        end
                        phase = 0;
                    end
                end
            end
        end
    endfunction

    task automatic drive(input ev_t e);
        @(negedge clk);
        prog   = e.p;
        button = e.b;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        prog   = 1'b0;
        button = 10'd0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic wait_episode(input string tag, input int ep0, input int budget);
        int n;
        n = 0;
        while (episodes == ep0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(episodes != ep0), 32'd1);
    endtask

    task automatic run_attempt(input string tag);
        int         res;
        int         ep0;
        logic [7:0] exp_code;
        exp_code = model_code;
        model_run(evq, exp_code, res);
        upd_cnt = 0;
        ep0     = episodes;
        foreach (evq[k]) drive(evq[k]);
        wait_episode(tag, ep0, 2000);
        chk({tag, "_led"},  32'(last_led), (res == 1) ? 32'(2'b10) : 32'(2'b01));
        chk({tag, "_len"},  32'(last_run), 32'(LED_ON_PERIOD));
        chk({tag, "_code"}, 32'(code), 32'(exp_code));
        chk({tag, "_upd"},  32'(upd_cnt), (res == 1) ? 32'd1 : 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        model_code = exp_code;
        evq.delete();
    endtask

    task automatic push_digits(input int a, input int b, input int c, input int d);
        evq.push_back(mk(1'b0, digit_key(a)));
        evq.push_back(mk(1'b0, digit_key(b)));
        evq.push_back(mk(1'b0, digit_key(c)));
        evq.push_back(mk(1'b0, digit_key(d)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, d1, kind, k;
        rst    = 1'b1;
        prog   = 1'b0;
        button = 10'd0;
        repeat (3) @(negedge clk);
        chk("rst_code", 32'(code), 32'h80);
        chk("rst_led",  32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_upd",  32'(code_update), 32'd0);
        rst        = 1'b0;
        model_code = 8'h80;

        // Keys while idle do nothing.
        upd_cnt = 0;
        drive(mk(1'b0, digit_key(3)));
        drive(mk(1'b0, 10'b0000001001));
        repeat (3) @(negedge clk);
        chk("idle_code", 32'(code), 32'h80);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_led",  32'(led), 32'd0);
        chk("idle_upd",  32'(upd_cnt), 32'd0);

        evq.push_back(mk(1'b1, 10'd0)); push_digits(3, 7, 3, 6);
        run_attempt("mismatch");
        chk("mismatch_abs", 32'(code), 32'h80);

        evq.push_back(mk(1'b1, 10'd0)); evq.push_back(mk(1'b0, 10'b0000001001));
        run_attempt("invalid");

        evq.push_back(mk(1'b1, 10'd0)); push_digits(3, 7, 3, 7);
        run_attempt("prog3737");
        chk("prog3737_abs", 32'(code), 32'h37);

        evq.push_back(mk(1'b1, 10'd0)); evq.push_back(mk(1'b0, digit_key(5)));
        evq.push_back(mk(1'b1, 10'd0)); push_digits(1, 2, 1, 2);
        run_attempt("restart");
        chk("restart_abs", 32'(code), 32'h12);

        evq.push_back(mk(1'b1, 10'd0)); evq.push_back(mk(1'b0, digit_key(4)));
        evq.push_back(mk(1'b1, digit_key(9))); push_digits(5, 6, 5, 6);
        run_attempt("coincide");
        chk("coincide_abs", 32'(code), 32'h56);

        // Reset in the middle of an entry restores the default code quietly.
        upd_cnt = 0;
        drive(mk(1'b1, 10'd0));
        drive(mk(1'b0, digit_key(1)));
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("midrst_code", 32'(code), 32'h80);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_upd",  32'(upd_cnt), 32'd0);
        model_code = 8'h80;

        upd_cnt = 0;
        k = episodes;
        drive(mk(1'b1, 10'd0));
        drive(mk(1'b0, digit_key(4)));
`ifdef CODE_WRITER_TIMEOUT_EN
        wait_episode("timeout", k, TIMEOUT + 800);
        chk("timeout_led",  32'(last_led), 32'(2'b01));
        chk("timeout_code", 32'(code), 32'h80);
        chk("timeout_upd",  32'(upd_cnt), 32'd0);
`else
        repeat (TIMEOUT + 100) @(negedge clk);
        chk("notimeout_busy", 32'(busy), 32'd1);
        chk("notimeout_led",  32'(led), 32'd0);
        chk("notimeout_code", 32'(code), 32'h80);
        chk("notimeout_ep",   32'(episodes - k), 32'd0);
        evq.push_back(mk(1'b1, 10'd0)); push_digits(2, 2, 2, 2);
        run_attempt("notimeout_resume");
`endif

        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 3);
            d0   = $urandom_range(0, 9);
            d1   = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) evq.push_back(mk(1'b0, digit_key($urandom_range(0, 9))));
            evq.push_back(mk(1'b1, 10'd0));
            case (kind)
                0: push_digits(d0, d1, d0, d1);
                1: push_digits(d0, d1, d0, (d1 + 1 + $urandom_range(0, 8)) % 10);
                2: begin
                    k = $urandom_range(0, 3);
                    for (int i = 0; i < k; i++) evq.push_back(mk(1'b0, digit_key($urandom_range(0, 9))));
                    evq.push_back(mk(1'b0, bad_key()));
                end
                default: begin
                    evq.push_back(mk(1'b0, digit_key($urandom_range(0, 9))));
                    evq.push_back(mk(1'b1, digit_key($urandom_range(0, 9))));
                    push_digits(d0, d1, d0, d1);
                end
            endcase
            run_attempt($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
